abft_check_sequencer: RTL and testbench
=======================================

Name: abft_check_sequencer

Overview:
- Control stage directly upstream of the lightweight ABFT checker.
- Drives the checker's checksum/product selects (s1, s2, s3) and its check-window reset (rst1).
- Sweeps the four check slots, samples the checker's registered error flag at the end of each window, and retries a failing slot up to a limit.
- Reports a per-slot error map, an error count, and a pass/fail summary to the system controller.

Parameters:
- WINDOW, 4: number of cycles rst1 is held high to accumulate (MAC vs accumulator) per attempt; legal range 1..255.
- MAX_RETRY, 2: extra attempts allowed for a slot after its first error; legal range 0..7.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; ignored unless IDLE.
- error_in  in  1  registered error flag from the checker.
- s1  out  2  column-checksum select to checker.
- s2  out  2  row-checksum select to checker.
- s3  out  2  product-row select to checker.
- rst1  out  1  check-window enable to checker; 0 clears MAC/accumulator, 1 accumulates.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of sweep.
- fail  out  1  sticky; set if any slot exhausted its retries; cleared on next accepted start.
- err_map  out  4  bit k set if slot k ever saw error_in=1 in the current sweep.
- err_count  out  8  total erroring attempts this sweep; saturates at 255.

Behaviour:
- Reset values: s1=s2=s3=0, rst1=0, busy=0, done=0, fail=0, err_map=0, err_count=0. Internal slot=0, retry=0, window counter=0, state=IDLE.
- s1, s2 and s3 are all driven from the registered slot index. They stay constant for a whole slot, including its retries.
- States:
  - IDLE: rst1=0. When start=1, clear fail, err_map and err_count, set slot=0, retry=0, go to CLEAR.
  - CLEAR: exactly 1 cycle, rst1=0 (flushes checker MAC/acc), then go to RUN.
  - RUN: rst1=1 for WINDOW cycles, counted by the window counter, then go to SAMPLE.
  - SAMPLE: exactly 1 cycle, rst1=1. error_in is captured on the edge leaving SAMPLE, then go to EVAL.
  - EVAL: 1 cycle, rst1=0.
    - If the captured error=0: advance.
    - If the captured error=1: set err_map[slot], increment err_count (saturating).
      - If retry<MAX_RETRY: retry+=1 and go to CLEAR.
      - Else: set fail and advance.
    - Advance means retry=0, then either slot+=1 and go to CLEAR, or, if slot=3, go to DONE.
  - DONE: 1 cycle with done=1, busy=0 on the next cycle, return to IDLE. slot stays at 3 until the next start.
- Latency of a clean sweep: 4 × (WINDOW+3) cycles from start acceptance to the done pulse. Default value: 28 cycles.
- The slot index never wraps beyond 3.
- start while busy: ignored, no effect on state or outputs.
- start and rst in the same cycle: rst wins.
- rst mid-sweep: all registers return to reset values on that edge. No done pulse is generated.
- error_in outside SAMPLE is ignored.

Optional Feature:
- Macro: ABFT_FIRST_FAIL_CAPTURE_EN.
- When defined, two extra ports are added:
  - first_slot, out, 2 bits.
  - first_valid, out, 1 bit.
- On the first erroring attempt of a sweep, the slot index is latched into first_slot and first_valid is set.
- Both registers hold until the next accepted start or rst, which clear them to 0.
- When the macro is undefined, these ports and registers do not exist and all other behaviour is identical.

Test Plan:
- Reset, then start with error_in held 0, WINDOW=4:
  - s1/s2/s3 step 0,1,2,3.
  - rst1 pattern per slot is 0,1,1,1,1,1,0.
  - done pulses 28 cycles after start; err_map=0000, err_count=0, fail=0.
- error_in=1 only during SAMPLE of slot 2's first attempt:
  - slot 2 is rerun once.
  - err_map=0100, err_count=1, fail=0.
  - Sweep completes in 28+7=35 cycles.
- error_in=1 during every SAMPLE of slot 1, MAX_RETRY=2:
  - Slot 1 runs 3 attempts; err_count=3, err_map=0010, fail=1.
  - Slots 2 and 3 still run; done asserted.
- start pulsed mid-sweep during slot 1 RUN:
  - No change in slot or counters; sweep finishes with normal timing.
- rst asserted during slot 2 RUN with err_map=0001:
  - Next cycle all outputs are 0 and state is IDLE.
  - No done pulse.
  - A subsequent start gives a clean 28-cycle sweep.
- With ABFT_FIRST_FAIL_CAPTURE_EN defined, errors injected on slots 3 then 1 in sweep order:
  - first_slot=1, first_valid=1.
  - Both clear on the next start.

Source files
------------

// File: rtl/abft_check_sequencer.sv
// Sequencer that drives the lightweight ABFT checker through its four check slots,
// retries failing slots and summarises the outcome. Optional: ABFT_FIRST_FAIL_CAPTURE_EN.
module abft_check_sequencer #(
    parameter int WINDOW    = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       error_in,
    output logic [1:0] s1,
    output logic [1:0] s2,
    output logic [1:0] s3,
    output logic       rst1,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] err_map,
    output logic [7:0] err_count
`ifdef ABFT_FIRST_FAIL_CAPTURE_EN
    ,
    output logic [1:0] first_slot,
    output logic       first_valid
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_EVAL   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [7:0] WIN_LAST  = 8'(WINDOW - 1);
    localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);

    state_t     state_r, state_s;
    logic [1:0] slot_r, slot_s;
    logic [2:0] retry_r, retry_s;
    logic [7:0] win_r, win_s;
    logic       err_cap_r, err_cap_s;
    logic [3:0] map_r, map_s;
    logic [7:0] cnt_r, cnt_s;
    logic       fail_r, fail_s;
    logic       rst1_r, rst1_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       advance_s;
`ifdef ABFT_FIRST_FAIL_CAPTURE_EN
    logic [1:0] first_slot_r, first_slot_s;
    logic       first_valid_r, first_valid_s;
`endif

    // Next-state, datapath updates and next values of the registered outputs
    always_comb begin
        state_s   = state_r;
        slot_s    = slot_r;
        retry_s   = retry_r;
        win_s     = win_r;
        err_cap_s = err_cap_r;
        map_s     = map_r;
        cnt_s     = cnt_r;
        fail_s    = fail_r;
        advance_s = 1'b0;
`ifdef ABFT_FIRST_FAIL_CAPTURE_EN
        first_slot_s  = first_slot_r;
        first_valid_s = first_valid_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    map_s   = 4'b0000;
                    cnt_s   = 8'd0;
                    fail_s  = 1'b0;
                    slot_s  = 2'd0;
                    retry_s = 3'd0;
                    state_s = ST_CLEAR;
`ifdef ABFT_FIRST_FAIL_CAPTURE_EN
                    first_slot_s  = 2'd0;
                    first_valid_s = 1'b0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                win_s   = 8'd0;
                state_s = ST_RUN;
            end
            ST_RUN: begin
                if (win_r == WIN_LAST) begin
                    win_s   = 8'd0;
                    state_s = ST_SAMPLE;
                end else begin
                    win_s   = win_r + 8'd1;
                end
            end
            ST_SAMPLE: begin
                err_cap_s = error_in;
                state_s   = ST_EVAL;
            end
            ST_EVAL: begin
                if (err_cap_r) begin
                    map_s[slot_r] = 1'b1;
                    if (cnt_r != 8'hFF) begin
                        cnt_s = cnt_r + 8'd1;
                    end else begin
                        cnt_s = cnt_r;
                    end
`ifdef ABFT_FIRST_FAIL_CAPTURE_EN
                    if (!first_valid_r) begin
                        first_slot_s  = slot_r;
                        first_valid_s = 1'b1;
                    end else begin
                        first_slot_s  = first_slot_r;
                    end
`endif
                    if (retry_r < RETRY_LIM) begin
                        retry_s = retry_r + 3'd1;
                        state_s = ST_CLEAR;
                    end else begin
                        fail_s    = 1'b1;
                        advance_s = 1'b1;
                    end
                end else begin
                    advance_s = 1'b1;
                end
                // Slot index saturates at 3; the last slot goes to DONE instead
                if (advance_s) begin
                    retry_s = 3'd0;
                    if (slot_r == 2'd3) begin
                        state_s = ST_DONE;
                    end else begin
                        slot_s  = slot_r + 2'd1;
                        state_s = ST_CLEAR;
                    end
                end else begin
                    slot_s = slot_r;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        rst1_s = (state_s == ST_RUN) || (state_s == ST_SAMPLE);
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            slot_r    <= 2'd0;
            retry_r   <= 3'd0;
            win_r     <= 8'd0;
            err_cap_r <= 1'b0;
            map_r     <= 4'b0000;
            cnt_r     <= 8'd0;
            fail_r    <= 1'b0;
            rst1_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef ABFT_FIRST_FAIL_CAPTURE_EN
            first_slot_r  <= 2'd0;
            first_valid_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            slot_r    <= slot_s;
            retry_r   <= retry_s;
            win_r     <= win_s;
            err_cap_r <= err_cap_s;
            map_r     <= map_s;
            cnt_r     <= cnt_s;
            fail_r    <= fail_s;
            rst1_r    <= rst1_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
`ifdef ABFT_FIRST_FAIL_CAPTURE_EN
            first_slot_r  <= first_slot_s;
            first_valid_r <= first_valid_s;
`endif
        end
    end

    assign s1        = slot_r;
    assign s2        = slot_r;
    assign s3        = slot_r;
    assign rst1      = rst1_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign fail      = fail_r;
    assign err_map   = map_r;
    assign err_count = cnt_r;
`ifdef ABFT_FIRST_FAIL_CAPTURE_EN
    assign first_slot  = first_slot_r;
    assign first_valid = first_valid_r;
`endif

endmodule

// File: tb/tb_abft_check_sequencer.sv
// Randomised self-checking bench for abft_check_sequencer against a per-cycle
// trace model built from slot/attempt rules.
module tb_abft_check_sequencer;

    localparam int WINDOW    = 4;
    localparam int MAX_RETRY = 2;

    logic       clk = 1'b0;
    logic       rst, start, error_in;
    logic [1:0] s1, s2, s3;
    logic       rst1, busy, done, fail;
    logic [3:0] err_map;
    logic [7:0] err_count;
`ifdef ABFT_FIRST_FAIL_CAPTURE_EN
    logic [1:0] first_slot;
    logic       first_valid;
`endif

    int ncmp  = 0;
    int nfail = 0;

    abft_check_sequencer #(.WINDOW(WINDOW), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst(rst), .start(start), .error_in(error_in),
        .s1(s1), .s2(s2), .s3(s3), .rst1(rst1), .busy(busy), .done(done),
        .fail(fail), .err_map(err_map), .err_count(err_count)
`ifdef ABFT_FIRST_FAIL_CAPTURE_EN
        , .first_slot(first_slot), .first_valid(first_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] s;
        logic       rst1;
        logic       busy;
        logic       done;
        logic       smp;
        logic       err;
    } ent_t;

    ent_t       exp_q[$];
    logic [7:0] pat [4];
    logic [3:0] exp_map;
    int         exp_cnt;
    logic       exp_fail;
    logic [1:0] exp_fs;
    logic       exp_fv;

    // Reference: each slot gets attempts until a clean one or MAX_RETRY+1 attempts
    task automatic build_model();
        ent_t e;
        exp_q.delete();
        exp_map = 4'b0; exp_cnt = 0; exp_fail = 1'b0; exp_fs = 2'd0; exp_fv = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int a = 0; a <= MAX_RETRY; a++) begin
                logic er;
                er = pat[s][a];
                e = '{s: 2'(s), rst1: 1'b0, busy: 1'b1, done: 1'b0, smp: 1'b0, err: 1'b0};
                exp_q.push_back(e);
                e.rst1 = 1'b1;
                for (int w = 0; w < WINDOW; w++) exp_q.push_back(e);
                e.smp = 1'b1; e.err = er;
                exp_q.push_back(e);
                e = '{s: 2'(s), rst1: 1'b0, busy: 1'b1, done: 1'b0, smp: 1'b0, err: 1'b0};
                exp_q.push_back(e);
                if (!er) break;
                exp_map[s] = 1'b1;
                if (exp_cnt < 255) exp_cnt++;
                if (!exp_fv) begin exp_fv = 1'b1; exp_fs = 2'(s); end
                if (a == MAX_RETRY) exp_fail = 1'b1;
            end
        end
        e = '{s: 2'd3, rst1: 1'b0, busy: 1'b1, done: 1'b1, smp: 1'b0, err: 1'b0};
        exp_q.push_back(e);
    endtask

    // Start a sweep and follow the model trace; stops early with rst driven at rst_at
    task automatic run_sweep(input bit start_noise, input int rst_at);
        ent_t e;
        @(negedge clk);
        start = 1'b1; error_in = 1'($urandom);
        @(posedge clk);
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q[j];
            ncmp += 6;
            if (s1 !== e.s) begin nfail++; $display("FAIL s1[%0d]: got %0d exp %0d", j, s1, e.s); end
            if (s2 !== e.s) begin nfail++; $display("FAIL s2[%0d]: got %0d exp %0d", j, s2, e.s); end
            if (s3 !== e.s) begin nfail++; $display("FAIL s3[%0d]: got %0d exp %0d", j, s3, e.s); end
            if (rst1 !== e.rst1) begin nfail++; $display("FAIL rst1[%0d]: got %b exp %b", j, rst1, e.rst1); end
            if (busy !== e.busy) begin nfail++; $display("FAIL busy[%0d]: got %b exp %b", j, busy, e.busy); end
            if (done !== e.done) begin nfail++; $display("FAIL done[%0d]: got %b exp %b", j, done, e.done); end
            if (j == 0) begin
                ncmp++;
                if ({err_map, err_count, fail} !== 13'd0) begin
                    nfail++; $display("FAIL start_clear: got map=%b cnt=%0d fail=%b exp 0", err_map, err_count, fail);
                end
`ifdef ABFT_FIRST_FAIL_CAPTURE_EN
                ncmp++;
                if ({first_slot, first_valid} !== 3'd0) begin
                    nfail++; $display("FAIL first_clear: got slot=%0d valid=%b exp 0", first_slot, first_valid);
                end
`endif
            end
            if (j == rst_at) begin
                rst = 1'b1; error_in = 1'b0;
                return;
            end
            error_in = e.smp ? e.err : 1'($urandom);
            if (start_noise) start = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0; error_in = 1'b0;
        ncmp += 5;
        if (busy !== 1'b0 || done !== 1'b0 || rst1 !== 1'b0) begin
            nfail++; $display("FAIL idle_ctl: got busy=%b done=%b rst1=%b exp 0", busy, done, rst1);
        end
        if (s1 !== 2'd3) begin nfail++; $display("FAIL idle_slot: got %0d exp 3", s1); end
        if (err_map !== exp_map) begin nfail++; $display("FAIL err_map: got %b exp %b", err_map, exp_map); end
        if (err_count !== 8'(exp_cnt)) begin nfail++; $display("FAIL err_count: got %0d exp %0d", err_count, exp_cnt); end
        if (fail !== exp_fail) begin nfail++; $display("FAIL fail: got %b exp %b", fail, exp_fail); end
`ifdef ABFT_FIRST_FAIL_CAPTURE_EN
        ncmp++;
        if ({first_slot, first_valid} !== {exp_fs, exp_fv}) begin
            nfail++; $display("FAIL first: got slot=%0d valid=%b exp slot=%0d valid=%b", first_slot, first_valid, exp_fs, exp_fv);
        end
`endif
    endtask

    task automatic clear_pat();
        for (int s = 0; s < 4; s++) pat[s] = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; error_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ncmp++;
        if ({s1, s2, s3, rst1, busy, done, fail, err_map, err_count} !== 23'd0) begin
            nfail++; $display("FAIL reset_outputs: got s=%0d rst1=%b busy=%b done=%b fail=%b map=%b cnt=%0d exp 0",
                              s1, rst1, busy, done, fail, err_map, err_count);
        end
        rst = 1'b0; start = 1'b0; error_in = 1'b0;
        @(negedge clk);
        ncmp++;
        if (busy !== 1'b0) begin nfail++; $display("FAIL reset_start: got busy=%b exp 0", busy); end
    endtask

    task automatic test_clean();
        clear_pat(); build_model();
        run_sweep(1'b0, -1);
    endtask

    task automatic test_single_retry();
        clear_pat(); pat[2] = 8'h01; build_model();
        run_sweep(1'b0, -1);
    endtask

    task automatic test_exhaust();
        clear_pat(); pat[1] = 8'hFF; build_model();
        run_sweep(1'b0, -1);
    endtask

    task automatic test_start_while_busy();
        clear_pat(); build_model();
        run_sweep(1'b1, -1);
    endtask

    task automatic test_reset_mid();
        clear_pat(); pat[0] = 8'h01; build_model();
        // index 23 lies inside slot 2's RUN phase (slot 0 took two attempts)
        run_sweep(1'b0, 23);
        ncmp++;
        if (err_map !== 4'b0001) begin nfail++; $display("FAIL mid_map: got %b exp 0001", err_map); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ncmp++;
        if ({s1, s2, s3, rst1, busy, done, fail, err_map, err_count} !== 23'd0) begin
            nfail++; $display("FAIL mid_reset: got s=%0d rst1=%b busy=%b done=%b map=%b cnt=%0d exp 0",
                              s1, rst1, busy, done, err_map, err_count);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ncmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                nfail++; $display("FAIL mid_no_done[%0d]: got done=%b busy=%b exp 0", k, done, busy);
            end
        end
        test_clean();
    endtask

    task automatic test_first_fail();
        clear_pat(); pat[3] = 8'h01; pat[1] = 8'h01; build_model();
        run_sweep(1'b0, -1);
        test_clean();
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            for (int s = 0; s < 4; s++) pat[s] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            build_model();
            run_sweep(1'b1, -1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; error_in = 1'b0;
        test_reset();
        test_clean();
        test_single_retry();
        test_exhaust();
        test_start_while_busy();
        test_reset_mid();
        test_first_fail();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
